cdb_arbiter: RTL
================

# cdb_arbiter

Shares the single common data bus (CDB) between the result producers of the out-of-order core (ALU 1, ALU 2, load/store buffer). It buffers one pending result per producer, selects one per cycle by round-robin, and broadcasts its value and ROB tag to the reservation stations and the ROB. The block sits between the functional-unit result ports and the RS/ROB wake-up inputs, and flushes on branch misprediction.

## Interface
- NUM_REQ, 3, number of producers; index 0 = ALU 1, 1 = ALU 2, 2 = LSB
- ROB_WIDTH, 4, ROB tag width
- REG_WIDTH, 32, result value width
- clk_in  input  1  system clock, rising edge
- rst_in  input  1  asynchronous, active-low reset
- rdy_in  input  1  when low, all state and outputs hold
- clear_signal  input  1  misprediction flush, synchronous, gated by rdy_in
- req_valid  input  NUM_REQ  producer i offers a result
- req_value  input  NUM_REQ*REG_WIDTH  value of producer i, bits [i*REG_WIDTH +: REG_WIDTH]
- req_tag  input  NUM_REQ*ROB_WIDTH  destination ROB tag of producer i, bits [i*ROB_WIDTH +: ROB_WIDTH]
- req_ready  output  NUM_REQ  combinational; slot i can accept this cycle
- cdb_stall  input  1  ROB/RS cannot take a broadcast this cycle
- cdb_valid  output  1  registered; broadcast valid
- cdb_value  output  REG_WIDTH  registered broadcast value
- cdb_tag  output  ROB_WIDTH  registered broadcast ROB tag
- cdb_src  output  clog2(NUM_REQ)  registered index of the producer broadcast
- pending  output  NUM_REQ  registered slot-occupied flags

## Operation
- Per producer: one holding slot (occupied flag, value, tag).
- req_ready[i] = rdy_in & ~clear_signal & (~pending[i] | grant[i]).
- Accept: at an edge with rdy_in & req_valid[i] & req_ready[i], the slot loads value/tag and pending[i] <= 1.
- Grant (combinational): when rdy_in & ~cdb_stall & ~clear_signal, grant the first occupied slot found starting at rr_ptr and scanning upward modulo NUM_REQ. Exactly one grant or none.
- On a grant of slot g at an edge: cdb_valid <= 1, cdb_value/cdb_tag/cdb_src <= slot g contents; pending[g] <= 0 unless it is reloaded at the same edge; rr_ptr <= (g+1) mod NUM_REQ.
- No grant at an edge with rdy_in high: cdb_valid <= 0; value/tag/src hold; rr_ptr holds.
- Simultaneous grant and accept on the same slot: the new result replaces the old one and pending stays 1. The broadcast carries the old contents.
- clear_signal & rdy_in at an edge: all pending <= 0, cdb_valid <= 0, rr_ptr <= 0. No accept and no grant at that edge. Results from before the flush are dropped.
- rdy_in low: no accept, no grant, req_ready = 0, all registers hold (cdb_valid included).
- Reset (rst_in low, asynchronous): pending = 0, cdb_valid = 0, cdb_value = 0, cdb_tag = 0, cdb_src = 0, rr_ptr = 0. The block stays in reset until rst_in rises; the first accept is possible at the first edge after that.

## Timing
- Latency: result accepted at edge k; broadcast earliest visible after edge k+1, i.e. 2 cycles from req_valid to cdb_valid.
- Throughput: 1 broadcast per cycle in total. Each producer can sustain 1 result per cycle while it wins the grant every cycle.
- Starvation bound: an occupied slot is granted within NUM_REQ non-stalled cycles.
- cdb_valid is high for one cycle per broadcast. Consumers sample it at the next edge; there is no handshake on the CDB side.
- cdb_stall is sampled combinationally in the grant cycle. While it stays high, pending slots hold and req_ready for full slots is 0.

## Test plan
- Single result: after reset, req_valid=001, tag0=5, value0=0x1234 for one cycle. Required: cdb_valid high exactly 2 cycles later with cdb_tag=5, cdb_value=0x1234, cdb_src=0; pending returns to 000.
- Three-way contention: all three producers offer one result each in the same cycle, tags 1/2/3. Required: broadcast order src 0,1,2 in 3 consecutive cycles; rr_ptr ends at 0.
- Round-robin fairness: producer 0 offers continuously, producer 1 offers once. Required: producer 1 is broadcast within 2 cycles and the sources alternate 0,1,0.
- Back-pressure: cdb_stall high for 4 cycles while slot 2 is full. Required: cdb_valid=0 throughout, req_ready[2]=0, and the held tag is broadcast the cycle after the stall drops.
- Flush: slots 0 and 1 pending; clear_signal pulses for one cycle. Required: pending=000, cdb_valid=0 next cycle, and no stale tag is ever broadcast.
- Async reset mid-operation: drop rst_in between edges while cdb_valid=1. Required: cdb_valid=0 and pending=000 immediately, without waiting for a clock edge; rdy_in low holds all outputs stable.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per result producer
// (0 = ALU 1, 1 = ALU 2, 2 = LSB), round-robin selection of one slot per
// cycle, and a registered broadcast of value, ROB tag and source index.
// rdy_in low freezes everything; clear_signal drops all held results.
module cdb_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int ROB_WIDTH = 4,
  parameter int REG_WIDTH = 32,
  localparam int SRC_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           rdy_in,
  input  logic                           clear_signal,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*REG_WIDTH-1:0]   req_value,
  input  logic [NUM_REQ*ROB_WIDTH-1:0]   req_tag,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           cdb_stall,
  output logic                           cdb_valid,
  output logic [REG_WIDTH-1:0]           cdb_value,
  output logic [ROB_WIDTH-1:0]           cdb_tag,
  output logic [SRC_W-1:0]               cdb_src,
  output logic [NUM_REQ-1:0]             pending
);

  logic [NUM_REQ-1:0]   pending_q, pending_d;
  logic [REG_WIDTH-1:0] slot_value_q [NUM_REQ];
  logic [REG_WIDTH-1:0] slot_value_d [NUM_REQ];
  logic [ROB_WIDTH-1:0] slot_tag_q   [NUM_REQ];
  logic [ROB_WIDTH-1:0] slot_tag_d   [NUM_REQ];
  logic [SRC_W-1:0]     rr_ptr_q, rr_ptr_d;

  logic                 cdb_valid_q, cdb_valid_d;
  logic [REG_WIDTH-1:0] cdb_value_q, cdb_value_d;
  logic [ROB_WIDTH-1:0] cdb_tag_q, cdb_tag_d;
  logic [SRC_W-1:0]     cdb_src_q, cdb_src_d;

  logic                 flow_en;
  logic                 grant_any;
  logic [SRC_W-1:0]     grant_idx;
  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ-1:0]   accept;
  int                   scan_dist;
  int                   scan_best;

  // Slots move only when the pipeline is running and no flush is in progress.
  assign flow_en = rdy_in & ~clear_signal;

  // Round-robin pick: the occupied slot closest to rr_ptr going upward wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_dist = 0;
    scan_best = NUM_REQ;
    if (flow_en && !cdb_stall) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        scan_dist = j - int'(rr_ptr_q);
        if (scan_dist < 0) begin
          scan_dist = scan_dist + NUM_REQ;
        end
        if (pending_q[j] && (scan_dist < scan_best)) begin
          scan_best = scan_dist;
          grant_idx = SRC_W'(j);
          grant_any = 1'b1;
        end
      end
    end
    grant = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;
  end

  // A slot that is being broadcast this cycle can be refilled at the same edge.
  assign req_ready = {NUM_REQ{flow_en}} & (~pending_q | grant);
  assign accept    = req_valid & req_ready;

  // Next-state for slots, broadcast registers and the round-robin pointer.
  always_comb begin
    pending_d    = pending_q;
    slot_value_d = slot_value_q;
    slot_tag_d   = slot_tag_q;
    rr_ptr_d     = rr_ptr_q;
    cdb_valid_d  = cdb_valid_q;
    cdb_value_d  = cdb_value_q;
    cdb_tag_d    = cdb_tag_q;
    cdb_src_d    = cdb_src_q;
    if (rdy_in) begin
      if (clear_signal) begin
        pending_d   = '0;
        cdb_valid_d = 1'b0;
        rr_ptr_d    = '0;
      end else begin
        pending_d = (pending_q & ~grant) | accept;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (accept[i]) begin
            slot_value_d[i] = req_value[i*REG_WIDTH +: REG_WIDTH];
            slot_tag_d[i]   = req_tag[i*ROB_WIDTH +: ROB_WIDTH];
          end
        end
        cdb_valid_d = grant_any;
        if (grant_any) begin
          // Broadcast reads the old slot contents even when it is refilled now.
          cdb_value_d = slot_value_q[grant_idx];
          cdb_tag_d   = slot_tag_q[grant_idx];
          cdb_src_d   = grant_idx;
          rr_ptr_d    = (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + SRC_W'(1);
        end
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pending_q   <= '0;
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_value_q <= '0;
      cdb_tag_q   <= '0;
      cdb_src_q   <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        slot_value_q[i] <= '0;
        slot_tag_q[i]   <= '0;
      end
    end else begin
      pending_q    <= pending_d;
      rr_ptr_q     <= rr_ptr_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_value_q  <= cdb_value_d;
      cdb_tag_q    <= cdb_tag_d;
      cdb_src_q    <= cdb_src_d;
      slot_value_q <= slot_value_d;
      slot_tag_q   <= slot_tag_d;
    end
  end

  assign pending   = pending_q;
  assign cdb_valid = cdb_valid_q;
  assign cdb_value = cdb_value_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_src   = cdb_src_q;

endmodule
